traffic_light_ctrl: RTL

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_pkg.sv | 8 +
 rtl/phase_timer.sv | 20 ++
 rtl/traffic_light_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings and controller state enum shared by the traffic light RTL
package traffic_pkg;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;
  typedef enum logic [2:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK, S_FLASH} state_e;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: phase cycle counter; done_o marks the last cycle (count == dur_i-1)
// Ports: clock, reset_n (async low), clear_i (sync clear), en_i (advance),
//        dur_i (phase length), done_o (count at dur_i-1)
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d  = clear_i ? '0 : en_i ? cnt_q + CNT_W'(1) : cnt_q;
  assign done_o = cnt_q == dur_i - CNT_W'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: multi-direction traffic light sequencer with pedestrian walk and flash mode
// Ports: clock, reset_n (async low), enable (advance timer), flash_mode (force flashing),
//        ped_req (walk request), light (3 one-hot bits per direction), ped_walk,
//        active_dir (direction holding or last holding green)
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR  = 2,
  parameter int CNT_W    = 8,
  parameter int GREEN_T  = 20,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2,
  parameter int WALK_T   = 10,
  parameter int FLASH_T  = 8,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 flash_mode,
  input  logic                 ped_req,
  output logic [3*NUM_DIR-1:0] light,
  output logic                 ped_walk,
  output logic [DIR_W-1:0]     active_dir
);
  localparam int MAX_T = (1 << CNT_W) - 1;
  if (NUM_DIR < 2 || NUM_DIR > 4) begin : g_bad_dir
    $error("NUM_DIR must be in 2..4");
  end
  if (GREEN_T < 1 || GREEN_T > MAX_T || YELLOW_T < 1 || YELLOW_T > MAX_T ||
      ALLRED_T < 1 || ALLRED_T > MAX_T || WALK_T < 1 || WALK_T > MAX_T ||
      FLASH_T < 1 || FLASH_T > MAX_T) begin : g_bad_dur
    $error("phase durations must be in 1..2^CNT_W-1");
  end
  state_e           state_q, state_d;
  logic [DIR_W-1:0] dir_q, dir_d, dir_nxt;
  logic             pend_q, pend_d, blink_q, blink_d, clr, done;
  logic [CNT_W-1:0] dur;
  assign dur = state_q == S_GREEN  ? CNT_W'(GREEN_T)  :
               state_q == S_YELLOW ? CNT_W'(YELLOW_T) :
               state_q == S_WALK   ? CNT_W'(WALK_T)   :
               state_q == S_FLASH  ? CNT_W'(FLASH_T)  : CNT_W'(ALLRED_T);
  assign dir_nxt = dir_q == DIR_W'(NUM_DIR - 1) ? '0 : dir_q + DIR_W'(1);
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (clr),
    .en_i    (enable),
    .dur_i   (dur),
    .done_o  (done)
  );
  // Flash handling sits ahead of the timed sequence so it overrides both enable and expiry;
  // in FLASH the timer wraps every FLASH_T cycles to pace the blink.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    blink_d = blink_q;
    pend_d  = pend_q | ped_req;
    clr     = 1'b0;
    if (flash_mode) begin
      state_d = S_FLASH;
      if (state_q != S_FLASH) begin
        blink_d = 1'b1;
        clr     = 1'b1;
      end else if (enable && done) begin
        blink_d = ~blink_q;
        clr     = 1'b1;
      end
    end else if (state_q == S_FLASH) begin
      state_d = S_ALLRED;
      clr     = 1'b1;
    end else if (enable && done) begin
      clr = 1'b1;
      case (state_q)
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = S_ALLRED;
        S_ALLRED: begin
          state_d = pend_q ? S_WALK : S_GREEN;
          dir_d   = pend_q ? dir_q : dir_nxt;
        end
        S_WALK: begin
          state_d = S_GREEN;
          dir_d   = dir_nxt;
          pend_d  = 1'b0;
        end
        default: state_d = S_ALLRED;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_ALLRED;
      dir_q   <= DIR_W'(NUM_DIR - 1);
      pend_q  <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
    end
  always_comb begin
    light = '0;
    for (int d = 0; d < NUM_DIR; d++)
      light[3*d +: 3] = state_q == S_FLASH   ? (blink_q ? LIGHT_YELLOW : LIGHT_OFF) :
                        DIR_W'(d) != dir_q   ? LIGHT_RED    :
                        state_q == S_GREEN   ? LIGHT_GREEN  :
                        state_q == S_YELLOW  ? LIGHT_YELLOW : LIGHT_RED;
  end
  assign ped_walk   = state_q == S_WALK;
  assign active_dir = dir_q;
endmodule
